// File: rtl/gcn_if.sv
// Memory-side bus of the gcn engine: weight/feature word port, COO edge port,
// and the start/done/result signals seen by the surrounding system.
interface gcn_if #(
   parameter int FEATURE_COLS      = 96,
   parameter int FEATURE_WIDTH     = 5,
   parameter int FEATURE_ROWS      = 6,
   parameter int COO_NUM_OF_ROWS   = 2,
   parameter int COO_BW            = 3,
   parameter int ADDRESS_WIDTH     = 13,
   parameter int MAX_ADDRESS_WIDTH = 2
);
   logic                                             start;
   logic [0:FEATURE_COLS-1][FEATURE_WIDTH-1:0]       data_in;
   logic [0:COO_NUM_OF_ROWS-1][COO_BW-1:0]           coo_in;
   logic [COO_BW-1:0]                                coo_address;
   logic [ADDRESS_WIDTH-1:0]                         read_address;
   logic                                             enable_read;
   logic                                             done;
   logic [0:FEATURE_ROWS-1][MAX_ADDRESS_WIDTH-1:0]   max_addi_answer;

   modport master (
      output start, data_in, coo_in,
      input  coo_address, read_address, enable_read, done, max_addi_answer
   );

   modport slave (
      input  start, data_in, coo_in,
      output coo_address, read_address, enable_read, done, max_addi_answer
   );
endinterface

// File: rtl/gcn.sv
// Single-layer graph convolution: FM x WM, neighbour aggregation over a COO
// edge list, then per-node argmax of the three class scores.
module gcn #(
   parameter int FEATURE_COLS      = 96,
   parameter int WEIGHT_ROWS       = 96,
   parameter int FEATURE_ROWS      = 6,
   parameter int WEIGHT_COLS       = 3,
   parameter int FEATURE_WIDTH     = 5,
   parameter int WEIGHT_WIDTH      = 5,
   parameter int DOT_PROD_WIDTH    = 16,
   parameter int ADDRESS_WIDTH     = 13,
   parameter int NUM_OF_NODES      = 6,
   parameter int COO_NUM_OF_COLS   = 6,
   parameter int COO_BW            = 3,
   parameter int MAX_ADDRESS_WIDTH = 2
) (
   input  logic  clk,
   input  logic  reset,
   gcn_if.slave  bus
);
   localparam logic [ADDRESS_WIDTH-1:0] FEAT_BASE = ADDRESS_WIDTH'('h200);

   typedef enum logic [2:0] {IDLE, READ_W, READ_F, AGG, ARGMAX, DONE} state_t;

   state_t                                           state_q;
   logic [COO_BW-1:0]                                cnt_q;
   logic [ADDRESS_WIDTH-1:0]                         addr_q;
   logic                                             en_q;
   logic [COO_BW-1:0]                                coo_q;
   logic                                             done_q;
   logic [0:FEATURE_ROWS-1][MAX_ADDRESS_WIDTH-1:0]   ans_q;

   logic [WEIGHT_WIDTH-1:0]   w_q   [WEIGHT_COLS][WEIGHT_ROWS];
   logic [DOT_PROD_WIDTH-1:0] fm_q  [FEATURE_ROWS][WEIGHT_COLS];
   logic [DOT_PROD_WIDTH-1:0] agg_q [NUM_OF_NODES][WEIGHT_COLS];
   logic [DOT_PROD_WIDTH-1:0] agg_d [NUM_OF_NODES][WEIGHT_COLS];
   logic [DOT_PROD_WIDTH-1:0] dot_d [WEIGHT_COLS];

   logic [COO_BW-1:0] src_id, dst_id, src_idx, dst_idx;
   logic              edge_ok;

   function automatic logic [MAX_ADDRESS_WIDTH-1:0] argmax(
      input logic [DOT_PROD_WIDTH-1:0] v [WEIGHT_COLS]);
      logic [DOT_PROD_WIDTH-1:0] best;
      logic [MAX_ADDRESS_WIDTH-1:0] idx;
      best = v[0];
      idx  = '0;
      // Strict compare keeps the lowest index on ties
      for (int c = 1; c < WEIGHT_COLS; c++) begin
         if (v[c] > best) begin
            best = v[c];
            idx  = MAX_ADDRESS_WIDTH'(c);
         end
      end
      return idx;
   endfunction

   always_comb begin
      for (int c = 0; c < WEIGHT_COLS; c++) begin
         dot_d[c] = '0;
         for (int k = 0; k < FEATURE_COLS; k++) begin
            dot_d[c] = dot_d[c] + DOT_PROD_WIDTH'(bus.data_in[k]) * DOT_PROD_WIDTH'(w_q[c][k]);
         end
      end
   end

   // Node ids arrive 1-based; ids outside 1..NUM_OF_NODES drop the whole edge
   always_comb begin
      agg_d   = agg_q;
      src_id  = bus.coo_in[0];
      dst_id  = bus.coo_in[1];
      src_idx = src_id - COO_BW'(1);
      dst_idx = dst_id - COO_BW'(1);
      edge_ok = (src_id != '0) && (src_id <= COO_BW'(NUM_OF_NODES)) &&
                (dst_id != '0) && (dst_id <= COO_BW'(NUM_OF_NODES));
      if (edge_ok) begin
         for (int c = 0; c < WEIGHT_COLS; c++) begin
            agg_d[src_idx][c] = agg_d[src_idx][c] + fm_q[dst_idx][c];
            agg_d[dst_idx][c] = agg_d[dst_idx][c] + fm_q[src_idx][c];
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         en_q    <= 1'b0;
         coo_q   <= '0;
         done_q  <= 1'b0;
         ans_q   <= '0;
         for (int c = 0; c < WEIGHT_COLS; c++)
            for (int k = 0; k < WEIGHT_ROWS; k++) w_q[c][k] <= '0;
         for (int r = 0; r < FEATURE_ROWS; r++)
            for (int c = 0; c < WEIGHT_COLS; c++) fm_q[r][c] <= '0;
         for (int n = 0; n < NUM_OF_NODES; n++)
            for (int c = 0; c < WEIGHT_COLS; c++) agg_q[n][c] <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.start) begin
                  state_q <= READ_W;
                  en_q    <= 1'b1;
                  addr_q  <= '0;
                  cnt_q   <= '0;
               end
            end
            READ_W: begin
               for (int k = 0; k < WEIGHT_ROWS; k++) w_q[cnt_q][k] <= bus.data_in[k];
               if (cnt_q == COO_BW'(WEIGHT_COLS - 1)) begin
                  state_q <= READ_F;
                  cnt_q   <= '0;
                  addr_q  <= FEAT_BASE;
               end else begin
                  cnt_q  <= cnt_q + COO_BW'(1);
                  addr_q <= addr_q + ADDRESS_WIDTH'(1);
               end
            end
            READ_F: begin
               for (int c = 0; c < WEIGHT_COLS; c++) fm_q[cnt_q][c] <= dot_d[c];
               if (cnt_q == COO_BW'(FEATURE_ROWS - 1)) begin
                  state_q <= AGG;
                  cnt_q   <= '0;
                  en_q    <= 1'b0;
                  coo_q   <= '0;
               end else begin
                  cnt_q  <= cnt_q + COO_BW'(1);
                  addr_q <= addr_q + ADDRESS_WIDTH'(1);
               end
            end
            AGG: begin
               agg_q <= agg_d;
               if (cnt_q == COO_BW'(COO_NUM_OF_COLS - 1)) begin
                  state_q <= ARGMAX;
               end else begin
                  cnt_q <= cnt_q + COO_BW'(1);
                  coo_q <= coo_q + COO_BW'(1);
               end
            end
            ARGMAX: begin
               for (int n = 0; n < NUM_OF_NODES; n++) ans_q[n] <= argmax(agg_q[n]);
               done_q  <= 1'b1;
               state_q <= DONE;
            end
            default: ;
         endcase
      end
   end

   assign bus.read_address    = addr_q;
   assign bus.enable_read     = en_q;
   assign bus.coo_address     = coo_q;
   assign bus.done            = done_q;
   assign bus.max_addi_answer = ans_q;
endmodule

// File: tb/tb_gcn.sv
// Directed and randomized checks of gcn against a plain-arithmetic model
// driven by a combinational memory responder.
module tb_gcn;
   logic clk;
   logic reset;
   int   errors = 0;
   int   checks = 0;

   int wm [3][96];
   int fm [6][96];
   int esrc [6];
   int edst [6];
   int aidx;
   logic [0:5][1:0] first_ans, re_ans, rnd_exp;

   gcn_if bus ();

   gcn dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory answers within the same cycle as the request
   always_comb begin
      bus.data_in = '0;
      aidx        = int'(bus.read_address);
      if (bus.enable_read) begin
         if (aidx < 3) begin
            for (int k = 0; k < 96; k++) bus.data_in[k] = 5'(wm[aidx][k]);
         end else if (aidx >= 'h200 && aidx < 'h206) begin
            for (int k = 0; k < 96; k++) bus.data_in[k] = 5'(fm[aidx - 'h200][k]);
         end
      end
      if (int'(bus.coo_address) < 6) begin
         bus.coo_in[0] = 3'(esrc[bus.coo_address]);
         bus.coo_in[1] = 3'(edst[bus.coo_address]);
      end else begin
         bus.coo_in = '0;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] outs();
      return {2'b00, bus.read_address, bus.enable_read, bus.coo_address, bus.done, bus.max_addi_answer};
   endfunction

   function automatic logic [0:5][1:0] model();
      int f [6][3];
      int ag [6][3];
      int s, d, best;
      logic [0:5][1:0] r;
      for (int n = 0; n < 6; n++) begin
         for (int c = 0; c < 3; c++) begin
            s = 0;
            for (int k = 0; k < 96; k++) s += fm[n][k] * wm[c][k];
            f[n][c]  = s % 65536;
            ag[n][c] = 0;
         end
      end
      for (int e = 0; e < 6; e++) begin
         s = esrc[e];
         d = edst[e];
         if (s >= 1 && s <= 6 && d >= 1 && d <= 6) begin
            for (int c = 0; c < 3; c++) begin
               ag[s-1][c] = (ag[s-1][c] + f[d-1][c]) % 65536;
               ag[d-1][c] = (ag[d-1][c] + f[s-1][c]) % 65536;
            end
         end
      end
      for (int n = 0; n < 6; n++) begin
         best = 0;
         for (int c = 1; c < 3; c++) if (ag[n][c] > ag[n][best]) best = c;
         r[n] = 2'(best);
      end
      return r;
   endfunction

   task automatic set_ring();
      for (int e = 0; e < 6; e++) begin
         esrc[e] = e + 1;
         edst[e] = (e + 1) % 6 + 1;
      end
   endtask

   task automatic fill(input int w0, input int w1, input int w2, input int fbase, input int fstep);
      for (int k = 0; k < 96; k++) begin
         wm[0][k] = w0;
         wm[1][k] = w1;
         wm[2][k] = w2;
         for (int r = 0; r < 6; r++) fm[r][k] = fbase + fstep * r;
      end
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk);
      reset     = 1'b0;
      bus.start = 1'b0;
      #1 check({tag, "_rst_outs"}, outs(), 32'h0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic run(input string tag, input logic [0:5][1:0] exp, output logic [0:5][1:0] got_ans);
      int addrs[$];
      int cyc;
      bit got;
      int want;
      @(negedge clk);
      bus.start = 1'b1;
      cyc = 0;
      got = 0;
      while (!got && cyc < 20) begin
         @(posedge clk);
         #1;
         cyc++;
         if (bus.enable_read) addrs.push_back(int'(bus.read_address));
         if (bus.done) got = 1;
      end
      check({tag, "_done_in_20"}, 32'(got), 32'h1);
      check({tag, "_addr_count"}, 32'(addrs.size()), 32'd9);
      for (int i = 0; i < 9; i++) begin
         want = (i < 3) ? i : ('h200 + i - 3);
         check($sformatf("%s_addr%0d", tag, i), (i < addrs.size()) ? 32'(addrs[i]) : 32'hFFFF, 32'(want));
      end
      check({tag, "_answer"}, 32'(bus.max_addi_answer), 32'(exp));
      check({tag, "_en_low"}, 32'(bus.enable_read), 32'h0);
      check({tag, "_addr_hold"}, 32'(bus.read_address), 32'h205);
      got_ans = bus.max_addi_answer;
      repeat (2) @(posedge clk);
      #1;
      check({tag, "_done_held"}, 32'(bus.done), 32'h1);
      check({tag, "_answer_held"}, 32'(bus.max_addi_answer), 32'(exp));
   endtask

   initial begin
      reset     = 1'b0;
      bus.start = 1'b0;
      fill(0, 0, 0, 0, 0);
      set_ring();
      #1 check("por_outs", outs(), 32'h0);
      repeat (2) @(negedge clk);
      reset = 1'b1;

      // Idle with start low: nothing moves
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1 check($sformatf("idle_outs%0d", i), outs(), 32'h0);
      end

      fill(1, 1, 1, 1, 0);
      set_ring();
      run("uniform", 12'h000, first_ans);

      do_reset("cls2");
      fill(0, 0, 1, 1, 1);
      run("class2", 12'hAAA, first_ans);

      do_reset("ovf");
      fill(1, 31, 1, 31, 0);
      run("overflow", 12'h555, first_ans);

      do_reset("iso");
      fill(2, 1, 1, 1, 0);
      for (int e = 0; e < 6; e++) begin
         esrc[e] = 1;
         edst[e] = 2;
      end
      run("isolated", 12'h000, first_ans);

      for (int t = 0; t < 5; t++) begin
         do_reset($sformatf("rnd%0d", t));
         for (int k = 0; k < 96; k++) begin
            for (int c = 0; c < 3; c++) wm[c][k] = $urandom_range(0, 31);
            for (int r = 0; r < 6; r++) fm[r][k] = $urandom_range(0, 31);
         end
         for (int e = 0; e < 6; e++) begin
            esrc[e] = ($urandom_range(0, 9) == 0) ? 7 * $urandom_range(0, 1) : $urandom_range(1, 6);
            edst[e] = $urandom_range(1, 6);
         end
         rnd_exp = model();
         run($sformatf("rand%0d", t), rnd_exp, first_ans);
      end

      // Abort in AGG, then rerun on the same data
      do_reset("abt");
      for (int k = 0; k < 96; k++) begin
         for (int c = 0; c < 3; c++) wm[c][k] = $urandom_range(0, 31);
         for (int r = 0; r < 6; r++) fm[r][k] = $urandom_range(0, 31);
      end
      set_ring();
      esrc[2] = 3;
      edst[2] = 5;
      rnd_exp = model();
      run("pre_abort", rnd_exp, first_ans);
      do_reset("abt2");
      @(negedge clk);
      bus.start = 1'b1;
      repeat (12) @(posedge clk);
      #2 reset = 1'b0;
      #1 check("abort_outs", outs(), 32'h0);
      bus.start = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      run("rerun", rnd_exp, re_ans);
      check("rerun_same", 32'(re_ans), 32'(first_ans));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/gcn.md
Name: gcn

Overview:
- Single-layer graph-convolution inference engine for a 6-node graph.
- Fetches the weight matrix and the feature matrix from an external memory port. Computes the transformation FM(6x96) x WM(96x3).
- Aggregates each node's neighbours using an edge list in COO form, read from a second external port.
- Outputs, per node, the index of the largest of its 3 aggregated class scores. Sits at the top of the accelerator; the surrounding system supplies the memories.

Parameters:
- FEATURE_COLS 96: features per node; equals WEIGHT_ROWS.
- WEIGHT_ROWS 96: weight-matrix rows.
- FEATURE_ROWS 6: number of nodes.
- WEIGHT_COLS 3: number of output classes.
- FEATURE_WIDTH 5: unsigned feature element width.
- WEIGHT_WIDTH 5: unsigned weight element width.
- DOT_PROD_WIDTH 16: width of dot products and aggregated sums.
- ADDRESS_WIDTH 13: read_address width.
- NUM_OF_NODES 6: graph nodes.
- COO_NUM_OF_COLS 6: number of edges.
- COO_NUM_OF_ROWS 2: source and destination rows.
- COO_BW 3: $clog2(COO_NUM_OF_COLS), width of a node id and of coo_address.
- MAX_ADDRESS_WIDTH 2: width of one argmax result.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  level; computation begins when sampled high in IDLE.
- data_in  in  96x5 packed [0:95][4:0]  one memory word. Element k sits at the MSB end for k=0.
- coo_in  in  2x3 packed [0:1][2:0]  [0]=source node id, [1]=destination node id of edge coo_address.
- coo_address  out  3  edge index 0..5.
- read_address  out  13  word address. 0..2 = weight column c (96 weights); 0x200+r = feature row r.
- enable_read  out  1  high while read_address is valid.
- done  out  1  results valid.
- max_addi_answer  out  6x2 packed [0:5][1:0]  argmax class per node, node 0 in the MSBs.

Behaviour:
- Reset (reset=0, async): state IDLE. All outputs 0: read_address, enable_read, coo_address, done, max_addi_answer. All internal accumulators cleared.
- Memory timing:
  - The address/enable (or coo_address) driven during a cycle returns data on data_in/coo_in before the next rising edge.
  - The DUT captures that data on that edge; no extra wait states.
- FSM, one word or edge per cycle:
  - IDLE: wait for start=1.
  - READ_W: enable_read=1, read_address = 0,1,2 in successive cycles; store 3 weight columns.
  - READ_F: read_address = 0x200+r, r=0..5. Each cycle compute fm_wm[r][c] = sum over k of feature[r][k]*weight[c][k], for c=0..2.
    - Operands are unsigned; the sum is truncated to 16 bits (mod 65536).
  - AGG: enable_read=0; coo_address = e, e=0..5.
    - Node ids on coo_in are 1-based (1..6); subtract 1.
    - The graph is undirected with no self-loops: agg[src] += fm_wm[dst] and agg[dst] += fm_wm[src], per column, 16-bit wrap.
    - Duplicate edges count twice. Ids 0 or 7 are ignored.
  - ARGMAX: for each node, max_addi_answer[node] = index c of the largest agg[node][c]. Unsigned compare; on a tie the lowest index wins. A node with no edges gets 0.
  - DONE: done=1 and max_addi_answer held until reset; start is ignored.
- Nominal latency: 3+6+6+1 = 16 cycles from the first start-high edge to done=1. Required bound: done within 20 cycles.
- When enable_read=0, read_address holds its last value.
- Reset asserted mid-operation aborts immediately to IDLE with all outputs 0. After release, a new start reruns from READ_W.

Test Plan:
- Reset then idle: reset=0 then 1 with start=0 for 5 cycles -> all outputs stay 0; enable_read never rises.
- Uniform data: all features=1, all weights=1, edges (1,2)(2,3)(3,4)(4,5)(5,6)(6,1).
  - Response: read_address sequence 0,1,2,0x200..0x205 with enable_read=1.
  - Every class score ties, so all max_addi_answer=0 and done=1 within 20 cycles.
- Class-2 dominant: weight col2=1, cols 0/1=0; feature row r all = r+1; ring edges as above -> max_addi_answer = 2 for every node.
- Overflow: features 31, weight col1=31, cols 0/2=1; ring edges.
  - fm_wm col1 = 92256 mod 65536 = 26720, col0/col2 = 2976; agg col1 = 53440 -> every node answers 1.
- Isolated node: edges (1,2) repeated 6 times, weight col0 larger -> nodes 1,2 answer 0 with sums sextupled; nodes 3..6 answer 0 (no edges).
- Abort: reset pulsed low during AGG -> outputs return to 0 at once. A rerun with identical data yields identical results.
